// File: rtl/am_inserter_if.sv
`default_nettype none
// ============================================================================
// Module      : am_inserter_if
// Description : Block stream and sideband bundle for the alignment-marker inserter.
// Revision    : 1.0
// ============================================================================
interface am_inserter_if;
    logic [65:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        corrupt_am;
    logic [65:0] out_data;
    logic        out_valid;
    logic        out_isam;
    logic [2:0]  out_am_seq;
    logic        fec_frame_start;
    logic        out_corrupt;

    // master: the upstream source / lane consumer; slave: the inserter itself
    modport master (
        output in_data, in_valid, corrupt_am,
        input  in_ready, out_data, out_valid, out_isam, out_am_seq,
               fec_frame_start, out_corrupt
    );

    modport slave (
        input  in_data, in_valid, corrupt_am,
        output in_ready, out_data, out_valid, out_isam, out_am_seq,
               fec_frame_start, out_corrupt
    );
endinterface
`default_nettype wire

// File: rtl/am_inserter.sv
`default_nettype none
// ============================================================================
// Module      : am_inserter
// Description : 25G lane TX alignment-marker inserter with running BIP and FEC frame flags.
// Revision    : 1.0
// ============================================================================
module am_inserter #(
    parameter int AM_PERIOD        = 16384,
    parameter int FEC_FRAME_BLOCKS = 20
) (
    input  wire logic    fullclk,
    input  wire logic    rst_n,
    am_inserter_if.slave bus
);
    localparam int c_SLOT_W = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
    localparam int c_FEC_W  = (FEC_FRAME_BLOCKS > 1) ? $clog2(FEC_FRAME_BLOCKS) : 1;
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(AM_PERIOD - 1);
    localparam logic [c_FEC_W-1:0]  c_FEC_LAST  = c_FEC_W'(FEC_FRAME_BLOCKS - 1);
    localparam logic [65:0]         c_IDLE      = {56'h0, 8'h1E, 2'b10};

    logic [c_SLOT_W-1:0] r_slot;
    logic [c_FEC_W-1:0]  r_fec;
    logic [7:0]          r_bip;
    logic [2:0]          r_am_seq;
    logic                r_corrupt_pend;

    logic [65:0]         r_out_data;
    logic                r_out_valid;
    logic                r_out_isam;
    logic [2:0]          r_out_am_seq;
    logic                r_fec_start;
    logic                r_out_corrupt;

    logic                w_is_am;
    logic                w_corrupt;
    logic [65:0]         w_block;
    logic [7:0]          w_block_xor;

    always_comb begin
        w_is_am     = (r_slot == '0);
        // a request arriving on the AM cycle itself still corrupts that AM
        w_corrupt   = r_corrupt_pend | bus.corrupt_am;
        w_block     = c_IDLE;
        w_block_xor = '0;
        if (w_is_am) begin
            w_block = {~r_bip, 8'hDE, 8'h97, 8'h3E, r_bip, 8'h21, 8'h68,
                       (w_corrupt ? 8'h3E : 8'hC1), 2'b10};
        end else if (bus.in_valid) begin
            w_block = bus.in_data;
        end
        for (int k = 0; k < 8; k++) begin
            w_block_xor = w_block_xor ^ w_block[2 + 8*k +: 8];
        end
    end

    // the FEC counter runs alongside the slot counter; AM_PERIOD being a
    // multiple of FEC_FRAME_BLOCKS keeps both at zero together on AM slots
    always_ff @(posedge fullclk) begin
        if (!rst_n) begin
            r_slot         <= '0;
            r_fec          <= '0;
            r_bip          <= '0;
            r_am_seq       <= '0;
            r_corrupt_pend <= 1'b0;
            r_out_data     <= '0;
            r_out_valid    <= 1'b0;
            r_out_isam     <= 1'b0;
            r_out_am_seq   <= '0;
            r_fec_start    <= 1'b0;
            r_out_corrupt  <= 1'b0;
        end else begin
            r_slot        <= (r_slot == c_SLOT_LAST) ? '0 : r_slot + c_SLOT_W'(1);
            r_fec         <= (r_fec == c_FEC_LAST) ? '0 : r_fec + c_FEC_W'(1);
            r_out_data    <= w_block;
            r_out_valid   <= 1'b1;
            r_out_isam    <= w_is_am;
            r_out_am_seq  <= w_is_am ? r_am_seq : 3'd0;
            r_fec_start   <= (r_fec == '0);
            r_out_corrupt <= w_is_am & w_corrupt;
            if (w_is_am) begin
                r_bip          <= '0;
                r_am_seq       <= r_am_seq + 3'd1;
                r_corrupt_pend <= 1'b0;
            end else begin
                r_bip <= r_bip ^ w_block_xor;
                if (bus.corrupt_am) begin
                    r_corrupt_pend <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready        = rst_n & ~w_is_am;
    assign bus.out_data        = r_out_data;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_isam        = r_out_isam;
    assign bus.out_am_seq      = r_out_am_seq;
    assign bus.fec_frame_start = r_fec_start;
    assign bus.out_corrupt     = r_out_corrupt;
endmodule
`default_nettype wire

// File: tb/tb_am_inserter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_am_inserter
// Description : Directed self-checking bench for am_inserter (AM_PERIOD=40, FEC=20).
// Revision    : 1.0
// ============================================================================
module tb_am_inserter;
    localparam int AM_PERIOD        = 40;
    localparam int FEC_FRAME_BLOCKS = 20;
    localparam logic [65:0] IDLE    = {56'h0, 8'h1E, 2'b10};

    logic fullclk = 1'b0;
    logic rst_n   = 1'b0;
    int   tests   = 0;
    int   fails   = 0;
    int   slot    = 0;      // slot the next edge registers
    int   prev_slot = 0;    // slot registered at the last edge
    logic [2:0] exp_seq = 3'd0;

    am_inserter_if bus ();

    am_inserter #(
        .AM_PERIOD       (AM_PERIOD),
        .FEC_FRAME_BLOCKS(FEC_FRAME_BLOCKS)
    ) dut (
        .fullclk(fullclk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    always #5 fullclk = ~fullclk;

    function automatic logic [65:0] am_block(input logic [7:0] bip, input logic corrupt);
        return {~bip, 8'hDE, 8'h97, 8'h3E, bip, 8'h21, 8'h68, (corrupt ? 8'h3E : 8'hC1), 2'b10};
    endfunction

    task automatic step();
        prev_slot = slot;
        if (!rst_n) slot = 0;
        else        slot = (slot == AM_PERIOD - 1) ? 0 : slot + 1;
        @(posedge fullclk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (bus.out_data !== 66'h0 || bus.out_valid !== 1'b0 || bus.out_isam !== 1'b0 ||
                bus.out_am_seq !== 3'd0 || bus.fec_frame_start !== 1'b0 || bus.out_corrupt !== 1'b0) begin
                fails++;
                $display("FAIL reset_outputs: data=%h valid=%b isam=%b seq=%0d fec=%b corrupt=%b, all required 0",
                         bus.out_data, bus.out_valid, bus.out_isam, bus.out_am_seq, bus.fec_frame_start, bus.out_corrupt);
            end
            tests++;
            if (bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL reset_in_ready: got %b required 0", bus.in_ready);
            end
        end
        rst_n = 1'b1;
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL first_slot_ready: got %b required 0", bus.in_ready);
        end
        step();
        tests++;
        if (bus.out_data !== am_block(8'h00, 1'b0) || bus.out_isam !== 1'b1 || bus.out_valid !== 1'b1 ||
            bus.fec_frame_start !== 1'b1 || bus.out_am_seq !== 3'd0 || bus.out_corrupt !== 1'b0) begin
            fails++;
            $display("FAIL first_am: data=%h isam=%b valid=%b fec=%b seq=%0d corrupt=%b required data=%h isam=1 valid=1 fec=1 seq=0 corrupt=0",
                     bus.out_data, bus.out_isam, bus.out_valid, bus.fec_frame_start, bus.out_am_seq, bus.out_corrupt,
                     am_block(8'h00, 1'b0));
        end
        exp_seq = 3'd1;
    endtask

    task automatic test_continuous();
        logic [65:0] pat = 66'h2_DEAD_BEEF_0000_0000;
        logic [65:0] sent;
        int lows = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tests++;
            if (bus.in_ready !== (slot != 0)) begin
                fails++;
                $display("FAIL cont_in_ready: slot %0d got %b required %b", slot, bus.in_ready, (slot != 0));
            end
            if (slot == 0) lows++;
            bus.in_data = pat;
            sent = pat;
            step();
            if (prev_slot != 0) begin
                pat = pat + 66'd1;
                tests++;
                if (bus.out_data !== sent || bus.out_isam !== 1'b0) begin
                    fails++;
                    $display("FAIL cont_data: slot %0d got %h isam=%b required %h isam=0",
                             prev_slot, bus.out_data, bus.out_isam, sent);
                end
            end else begin
                tests++;
                if (bus.out_isam !== 1'b1 || bus.out_am_seq !== exp_seq) begin
                    fails++;
                    $display("FAIL cont_am: isam=%b seq=%0d required isam=1 seq=%0d", bus.out_isam, bus.out_am_seq, exp_seq);
                end
                exp_seq = exp_seq + 3'd1;
            end
            tests++;
            if (bus.fec_frame_start !== (prev_slot % FEC_FRAME_BLOCKS == 0)) begin
                fails++;
                $display("FAIL cont_fec: slot %0d got %b required %b", prev_slot, bus.fec_frame_start,
                         (prev_slot % FEC_FRAME_BLOCKS == 0));
            end
        end
        tests++;
        if (lows != 2) begin
            fails++;
            $display("FAIL cont_ready_lows: got %0d required 2", lows);
        end
    endtask

    task automatic test_bip();
        bus.in_valid = 1'b1;
        bus.in_data  = {56'h0, 8'h01, 2'b01};
        for (int i = 0; i < 39; i++) step();
        step();
        tests++;
        if (bus.out_data !== am_block(8'h01, 1'b0) || bus.out_isam !== 1'b1 || bus.out_am_seq !== exp_seq) begin
            fails++;
            $display("FAIL bip_ones: got %h isam=%b seq=%0d required %h isam=1 seq=%0d",
                     bus.out_data, bus.out_isam, bus.out_am_seq, am_block(8'h01, 1'b0), exp_seq);
        end
        exp_seq = exp_seq + 3'd1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 39; i++) begin
            step();
            tests++;
            if (bus.out_data !== IDLE) begin
                fails++;
                $display("FAIL bip_idle_block: slot %0d got %h required %h", prev_slot, bus.out_data, IDLE);
            end
        end
        step();
        tests++;
        if (bus.out_data !== am_block(8'h1E, 1'b0) || bus.out_isam !== 1'b1) begin
            fails++;
            $display("FAIL bip_idles: got %h isam=%b required %h isam=1", bus.out_data, bus.out_isam, am_block(8'h1E, 1'b0));
        end
        exp_seq = exp_seq + 3'd1;
    endtask

    task automatic test_idle_fill();
        logic [65:0] exp;
        bus.in_data = {56'h0, 8'h02, 2'b01};
        for (int i = 0; i < 39; i++) begin
            bus.in_valid = !(i >= 10 && i < 15);
            exp = bus.in_valid ? bus.in_data : IDLE;
            step();
            tests++;
            if (bus.out_data !== exp || bus.out_isam !== 1'b0) begin
                fails++;
                $display("FAIL idle_fill_block: slot %0d got %h isam=%b required %h isam=0",
                         prev_slot, bus.out_data, bus.out_isam, exp);
            end
        end
        bus.in_valid = 1'b1;
        step();
        tests++;
        if (bus.out_data !== am_block(8'h1E, 1'b0) || bus.out_isam !== 1'b1) begin
            fails++;
            $display("FAIL idle_fill_am: got %h isam=%b required %h isam=1", bus.out_data, bus.out_isam, am_block(8'h1E, 1'b0));
        end
        exp_seq = exp_seq + 3'd1;
    endtask

    task automatic test_corruption();
        int          pa[9]   = '{10, 5, -1, 0, -1, -1, -1, -1, -1};
        int          pb[9]   = '{-1, 25, -1, -1, -1, -1, -1, -1, -1};
        logic        exp_c[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [2:0]  seqs[9] = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        bus.in_valid = 1'b1;
        bus.in_data  = {64'h0, 2'b01};
        for (int p = 0; p < 9; p++) begin
            for (int k = 0; k < AM_PERIOD; k++) begin
                bus.corrupt_am = (slot == pa[p]) || (slot == pb[p]);
                step();
            end
            bus.corrupt_am = 1'b0;
            tests++;
            if (bus.out_data !== am_block(8'h00, exp_c[p]) || bus.out_corrupt !== exp_c[p] ||
                bus.out_isam !== 1'b1 || bus.out_am_seq !== seqs[p]) begin
                fails++;
                $display("FAIL corrupt_am_%0d: data=%h corrupt=%b isam=%b seq=%0d required data=%h corrupt=%b isam=1 seq=%0d",
                         p, bus.out_data, bus.out_corrupt, bus.out_isam, bus.out_am_seq,
                         am_block(8'h00, exp_c[p]), exp_c[p], seqs[p]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1;
        bus.in_data  = {56'h0, 8'h55, 2'b01};
        while (slot != 17) begin
            bus.corrupt_am = (slot == 3);
            step();
        end
        bus.corrupt_am = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_ready: got %b required 0", bus.in_ready);
        end
        step();
        tests++;
        if (bus.out_data !== 66'h0 || bus.out_valid !== 1'b0 || bus.out_isam !== 1'b0 ||
            bus.fec_frame_start !== 1'b0 || bus.out_corrupt !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_outputs: data=%h valid=%b isam=%b fec=%b corrupt=%b required all 0",
                     bus.out_data, bus.out_valid, bus.out_isam, bus.fec_frame_start, bus.out_corrupt);
        end
        rst_n = 1'b1;
        step();
        tests++;
        if (bus.out_data !== am_block(8'h00, 1'b0) || bus.out_am_seq !== 3'd0 || bus.out_isam !== 1'b1 ||
            bus.out_corrupt !== 1'b0 || bus.fec_frame_start !== 1'b1 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_am: data=%h seq=%0d isam=%b corrupt=%b fec=%b valid=%b required data=%h seq=0 isam=1 corrupt=0 fec=1 valid=1",
                     bus.out_data, bus.out_am_seq, bus.out_isam, bus.out_corrupt, bus.fec_frame_start, bus.out_valid,
                     am_block(8'h00, 1'b0));
        end
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_ready_after: got %b required 1", bus.in_ready);
        end
        step();
        tests++;
        if (bus.out_data !== bus.in_data || bus.out_isam !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_data: got %h required %h", bus.out_data, {56'h0, 8'h55, 2'b01});
        end
    endtask

    initial begin
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.corrupt_am = 1'b0;
        #1;
        test_reset();
        test_continuous();
        test_bip();
        test_idle_fill();
        test_corruption();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/am_inserter.md
# am_inserter

Transmit-side alignment-marker inserter for one 25G PCS lane. Sits between the 64b/66b encoder and the lane serializer in the bench TX path. Consumes 66-bit blocks over a valid/ready handshake and emits one block per `fullclk` cycle. Every `AM_PERIOD` slots it inserts an alignment marker carrying a running BIP, and it flags FEC frame starts, so the RX lane monitor can be driven end to end.

## Interface
- `AM_PERIOD`, 16384: output slots per AM period, including the AM slot; must be a multiple of `FEC_FRAME_BLOCKS` and ≥ 2.
- `FEC_FRAME_BLOCKS`, 20: output slots per FEC frame.
- `fullclk`  in  1  single block clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_data`  in  66  upstream block; `[1:0]` = sync, byte k = bits `[9+8k:2+8k]`.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepted this cycle when `in_valid & in_ready`.
- `corrupt_am`  in  1  request that the next AM be corrupted.
- `out_data`  out  66  registered output block.
- `out_valid`  out  1  `out_data` is meaningful.
- `out_isam`  out  1  `out_data` is an AM.
- `out_am_seq`  out  3  AM sequence number mod 8, valid with `out_isam`.
- `fec_frame_start`  out  1  `out_data` is the first block of an FEC frame.
- `out_corrupt`  out  1  `out_data` is a deliberately corrupted AM.

## Operation
- **Slot counter `s`:** range 0..`AM_PERIOD`-1. It selects the content registered this cycle, which appears on the outputs the next cycle. It increments every non-reset cycle and wraps `AM_PERIOD`-1 → 0.
- **`s == 0` (AM slot):**
  - `in_ready` = 0.
  - `out_data` is registered with sync `2'b10` and bytes M0..M7 = `C1, 68, 21, BIP3, 3E, 97, DE, BIP7`.
  - BIP3 = `bip_acc`; BIP7 = ~`bip_acc`.
- **`s != 0`:** `in_ready` = 1.
  - If `in_valid` = 1: register `in_data` unchanged.
  - If `in_valid` = 0: register the idle block, sync `2'b10`, byte0 = `1E`, bytes 1..7 = `00`.
- **`bip_acc` (8 bit):**
  - Every non-AM block registered XORs all 8 payload bytes into it; idles count.
  - When an AM is registered, `bip_acc` clears to 0 in the same edge. The next block's XOR therefore starts from 0.
- **AM sequence:** `am_seq` is a 3-bit counter. `out_am_seq` shows the value used for the current AM. It increments after each AM and wraps 7 → 0.
- **Corruption:**
  - A `corrupt_am` sample of 1 in any cycle sets a sticky `corrupt_pend` flag.
  - The next AM registered while `corrupt_pend` is set (including an AM in the same cycle as the request) has M0 = `3E` (inverted) and raises `out_corrupt`.
  - `corrupt_pend` then clears. Multiple requests before one AM corrupt only that one AM.
- **FEC frame start:** `fec_frame_start` is registered high when `s % FEC_FRAME_BLOCKS == 0`. It is therefore always high with each AM.
- **`in_ready`:** a combinational function of `s` and the reset state only. It never depends on `in_valid`.

## Timing
- **Reset** (`rst_n` = 0 sampled at an edge): `s`=0, `bip_acc`=0, `am_seq`=0, `corrupt_pend`=0.
  - All outputs are 0: `out_data`=66'h0, `out_valid`, `out_isam`, `out_am_seq`, `fec_frame_start`, `out_corrupt`.
  - `in_ready`=0 while `rst_n`=0.
- **After reset:** in the first cycle with `rst_n`=1, slot 0 is registered. One cycle later `out_valid`=1 and the first AM appears with BIP3=`00`, BIP7=`FF`, `out_am_seq`=0.
- **Steady state:** `out_valid` stays 1 every cycle until the next reset.
- **Latency:** exactly 1 cycle from acceptance to `out_data`. Sideband flags align with their block.
- **AM spacing:** the AM appears every `AM_PERIOD` cycles. There are `AM_PERIOD`-1 data/idle slots between AMs.
- **Reset mid-operation:** takes effect at the next edge. Partial BIP, pending corruption and sequence are discarded. No block is accepted in a reset cycle.

## Test plan
- **Reset and first AM.** Params `AM_PERIOD`=40, `FEC_FRAME_BLOCKS`=20; hold `rst_n`=0 for 3 cycles, then release.
  - All outputs are 0 during reset.
  - One cycle after release: `out_isam`=1, bytes `C1 68 21 00 3E 97 DE FF`, `fec_frame_start`=1.
- **Continuous traffic.** `in_valid`=1 with an incrementing pattern.
  - `in_ready` is low exactly once per 40 cycles.
  - Data appears 1 cycle later, unmodified and with no loss.
  - `fec_frame_start` pulses every 20 cycles.
- **BIP check.** Feed 39 blocks, each with byte0=`01` and other bytes `00`.
  - Next AM has BIP3=`01`, BIP7=`FE`.
  - With all-idle input, BIP3=`1E` (39 odd).
- **Idle fill.** `in_valid`=0 for 5 cycles mid-period.
  - Five idle blocks (`1E` + zeros) are emitted.
  - The AM position is unchanged.
- **Corruption.** Pulse `corrupt_am` once mid-period, then again twice before the following AM.
  - Each following AM has M0=`3E` and `out_corrupt`=1.
  - All other AMs are clean.
  - `out_am_seq` counts 0..7 and wraps to 0.
- **Reset mid-period.** Assert `rst_n`=0 at `s`=17.
  - Outputs drop to 0 at the next edge.
  - After release, the first AM has BIP3=`00` and `out_am_seq`=0.
